// File: rtl/lmac_acc.sv
// Q31 multiply-accumulate tail: saturating accumulation of len products, then
// Q15 round-to-nearest of the result, held until the consumer takes it.
module lmac_acc #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_prod,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_acc,
  output logic [15:0]      out_q15,
  output logic             sat_flag
);

  localparam int unsigned ACC_W = 32;
  localparam int unsigned Q15_W = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc, acc_nx, out_acc_nx;
  logic [LEN_W-1:0]   cnt, cnt_nx;
  logic [Q15_W-1:0]   out_q15_nx;
  logic               sat_nx;
  logic [ACC_W:0]     sum_c;
  logic [ACC_W:0]     rnd_c;

  // Returns {clamped, result} for a signed 32-bit add clamped to the Q31 range.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, s[ACC_W] ? 32'h8000_0000 : 32'h7FFF_FFFF};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign sum_c = sat_add(acc, in_prod);
  assign rnd_c = sat_add(sum_c[ACC_W-1:0], 32'h0000_8000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    cnt_nx     = cnt;
    out_acc_nx = out_acc;
    out_q15_nx = out_q15;
    sat_nx     = sat_flag;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nx = '0;
          sat_nx = 1'b0;
          if (len != '0) begin
            cnt_nx   = len;
            state_nx = ACCUM;
          end else begin
            cnt_nx     = '0;
            out_acc_nx = '0;
            out_q15_nx = '0;
            state_nx   = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid && in_ready) begin
          acc_nx = sum_c[ACC_W-1:0];
          cnt_nx = cnt - LEN_W'(1);
          sat_nx = sat_flag | sum_c[ACC_W];
          // Final beat: publish result and its rounded Q15 form in the same edge.
          if (cnt == LEN_W'(1)) begin
            out_acc_nx = sum_c[ACC_W-1:0];
            out_q15_nx = rnd_c[ACC_W-1:ACC_W-Q15_W];
            sat_nx     = sat_flag | sum_c[ACC_W] | rnd_c[ACC_W];
            state_nx   = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_q15   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      in_ready  <= (state_nx == ACCUM);
      out_valid <= (state_nx == DONE);
      out_acc   <= out_acc_nx;
      out_q15   <= out_q15_nx;
      sat_flag  <= sat_nx;
    end
  end

endmodule

// File: tb/tb_lmac_acc.sv
// Self-checking bench for lmac_acc: directed corner cases plus randomized jobs
// checked against an integer-arithmetic reference model.
module tb_lmac_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_prod = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_acc;
  logic [15:0] out_q15;
  logic        sat_flag;

  int total = 0;
  int bad = 0;

  logic [31:0] job_terms[8];
  int          job_gaps[8];

  logic [31:0] r_acc;
  logic [15:0] r_q15;
  logic        r_sat;
  bit          r_lat, r_hold, r_idle;
  int          r_cyc;

  lmac_acc #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_q15(out_q15), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum clamped after every term, then round-half-up to Q15.
  task automatic ref_model(input int n, output logic [31:0] ea,
                           output logic [15:0] eq, output logic es);
    longint a, r;
    a = 0;
    es = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a + longint'($signed(job_terms[i]));
      if (a > 64'sd2147483647) begin a = 64'sd2147483647; es = 1'b1; end
      else if (a < -64'sd2147483648) begin a = -64'sd2147483648; es = 1'b1; end
    end
    r = a + 32768;
    if (r > 64'sd2147483647) begin r = 64'sd2147483647; es = 1'b1; end
    ea = 32'(a);
    eq = 16'(r >>> 16);
  endtask

  // Drives one job from the current negedge through the result handshake.
  task automatic run_job(input int n, input int rdy_dly, input bit stray);
    r_cyc = 0;
    r_lat = 1'b1;
    start = 1'b1;
    len = 8'(n);
    @(negedge clk); r_cyc++;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (job_gaps[i]) begin
        in_valid = 1'b0;
        @(negedge clk); r_cyc++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) r_lat = 1'b0;
      end
      in_valid = 1'b1;
      in_prod = job_terms[i];
      @(negedge clk); r_cyc++;
      in_valid = 1'b0;
      in_prod = $urandom;
      if (i < n - 1 && out_valid !== 1'b0) r_lat = 1'b0;
    end
    if (out_valid !== 1'b1 || in_ready !== 1'b0) r_lat = 1'b0;
    r_acc = out_acc;
    r_q15 = out_q15;
    r_sat = sat_flag;
    r_hold = 1'b1;
    for (int d = 0; d < rdy_dly; d++) begin
      start = stray && (d == 0);
      @(negedge clk); r_cyc++;
      start = 1'b0;
      if (out_valid !== 1'b1 || out_acc !== r_acc || out_q15 !== r_q15 || sat_flag !== r_sat)
        r_hold = 1'b0;
    end
    out_ready = 1'b1;
    start = stray;
    @(negedge clk); r_cyc++;
    out_ready = 1'b0;
    start = 1'b0;
    r_idle = (out_valid === 1'b0 && in_ready === 1'b0);
  endtask

  task automatic set_job(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    job_terms[0] = t0; job_terms[1] = t1; job_terms[2] = t2;
    for (int i = 0; i < 8; i++) job_gaps[i] = 0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({in_ready, out_valid, out_acc, out_q15, sat_flag} !== 51'd0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b acc=%h q15=%h sat=%b exp all zero",
               in_ready, out_valid, out_acc, out_q15, sat_flag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got rdy=%b vld=%b exp 0/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    set_job(32'h2000_0000, 32'h1000_0000, 32'h0);
    run_job(2, 0, 1'b0);
    total++;
    if ({r_acc, r_q15, r_sat} !== {32'h3000_0000, 16'h3000, 1'b0}) begin
      bad++;
      $display("FAIL basic_sum got %h/%h/%b exp 30000000/3000/0", r_acc, r_q15, r_sat);
    end
    total++;
    if (!r_lat || !r_idle) begin
      bad++;
      $display("FAIL basic_latency got lat_ok=%b idle_ok=%b exp 1/1", r_lat, r_idle);
    end
  endtask

  task automatic test_saturation();
    set_job(32'h7FFF_FFFF, 32'h0000_0001, 32'h0);
    run_job(2, 1, 1'b0);
    total++;
    if ({r_acc, r_q15, r_sat} !== {32'h7FFF_FFFF, 16'h7FFF, 1'b1}) begin
      bad++;
      $display("FAIL sat_pos got %h/%h/%b exp 7fffffff/7fff/1", r_acc, r_q15, r_sat);
    end
    set_job(32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_job(2, 0, 1'b0);
    total++;
    if ({r_acc, r_q15, r_sat} !== {32'h8000_0000, 16'h8000, 1'b1}) begin
      bad++;
      $display("FAIL sat_neg got %h/%h/%b exp 80000000/8000/1", r_acc, r_q15, r_sat);
    end
    // Sum fits but rounding overflows: only the rounding step may raise the flag.
    set_job(32'h7FFF_FFFF, 32'h0, 32'h0);
    run_job(1, 0, 1'b0);
    total++;
    if ({r_acc, r_q15, r_sat} !== {32'h7FFF_FFFF, 16'h7FFF, 1'b1}) begin
      bad++;
      $display("FAIL sat_round got %h/%h/%b exp 7fffffff/7fff/1", r_acc, r_q15, r_sat);
    end
    set_job(32'h4000_0000, 32'h0, 32'h0);
    run_job(1, 0, 1'b0);
    total++;
    if (r_sat !== 1'b0) begin
      bad++;
      $display("FAIL sat_cleared got sat=%b exp 0", r_sat);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] ins[3];
    logic [15:0] exps[3];
    ins = '{32'h0001_8000, 32'hFFFF_7FFF, 32'h0000_7FFF};
    exps = '{16'h0002, 16'hFFFF, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      set_job(ins[k], 32'h0, 32'h0);
      run_job(1, 0, 1'b0);
      total++;
      if (r_q15 !== exps[k] || r_sat !== 1'b0 || r_acc !== ins[k]) begin
        bad++;
        $display("FAIL round_%0d got %h/%h/%b exp %h/%h/0", k, r_acc, r_q15, r_sat, ins[k], exps[k]);
      end
    end
  endtask

  task automatic test_gapped();
    set_job(32'h0123_4567, 32'hF000_0000, 32'h0765_4321);
    job_gaps[1] = 2;
    job_gaps[2] = 1;
    run_job(3, 3, 1'b1);
    total++;
    if ({r_acc, r_q15, r_sat} !== {32'hF888_8888, 16'hF889, 1'b0}) begin
      bad++;
      $display("FAIL gapped_sum got %h/%h/%b exp f8888888/f889/0", r_acc, r_q15, r_sat);
    end
    total++;
    if (!r_lat || !r_hold || !r_idle) begin
      bad++;
      $display("FAIL gapped_hold got lat=%b hold=%b idle=%b exp 1/1/1", r_lat, r_hold, r_idle);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stray_start got rdy=%b vld=%b exp 0/0", in_ready, out_valid);
    end
  endtask

  task automatic test_len0_and_reset();
    run_job(0, 1, 1'b0);
    total++;
    if ({r_acc, r_q15, r_sat, r_lat} !== {32'h0, 16'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL len0 got %h/%h/%b lat=%b exp 0/0/0 lat=1", r_acc, r_q15, r_sat, r_lat);
    end
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_prod = 32'h7000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_acc, out_q15, sat_flag} !== 51'd0) begin
      bad++;
      $display("FAIL reset_mid_accum got rdy=%b vld=%b acc=%h exp all zero", in_ready, out_valid, out_acc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_prod = 32'h0100_0000;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL wait_fresh_start got rdy=%b vld=%b exp 0/0", in_ready, out_valid);
    end
    set_job(32'h0005_0000, 32'h0, 32'h0);
    run_job(1, 0, 1'b0);
    total++;
    if ({r_acc, r_q15, r_sat} !== {32'h0005_0000, 16'h0005, 1'b0}) begin
      bad++;
      $display("FAIL after_reset got %h/%h/%b exp 00050000/0005/0", r_acc, r_q15, r_sat);
    end
    start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_prod = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_acc !== 32'h0 || out_q15 !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_done got vld=%b acc=%h q15=%h exp 0/0/0", out_valid, out_acc, out_q15);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      set_job($urandom, $urandom, $urandom);
      run_job(j % 3 + 1, 0, 1'b0);
      total++;
      if (r_cyc != j % 3 + 3) begin
        bad++;
        $display("FAIL b2b_cycles_%0d got %0d exp %0d", j, r_cyc, j % 3 + 3);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ea;
    logic [15:0] eq;
    logic        es;
    int          n;
    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(6, 1);
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(3, 0))
          0: job_terms[i] = 32'h7FFF_0000 | 32'($urandom_range(65535, 0));
          1: job_terms[i] = 32'h8000_0000 | 32'($urandom_range(65535, 0));
          2: job_terms[i] = 32'($signed($urandom) >>> 10);
          default: job_terms[i] = $urandom;
        endcase
        job_gaps[i] = $urandom_range(2, 0);
      end
      ref_model(n, ea, eq, es);
      run_job(n, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      total++;
      if ({r_acc, r_q15, r_sat, r_lat, r_hold, r_idle} !== {ea, eq, es, 3'b111}) begin
        bad++;
        $display("FAIL random_%0d got %h/%h/%b flags=%b%b%b exp %h/%h/%b flags=111",
                 j, r_acc, r_q15, r_sat, r_lat, r_hold, r_idle, ea, eq, es);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin job_terms[i] = '0; job_gaps[i] = 0; end
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_gapped();
    test_len0_and_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lmac_acc.md
LMAC_ACC -- requirements
Module: lmac_acc

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, giving the bit width of the term-count input len.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle request to begin a new accumulation; honoured only in IDLE.
REQ-005 len  input  LEN_W  number of Q31 terms to accumulate (unsigned); sampled when start is honoured.
REQ-006 in_valid  input  1  in_prod carries a valid term.
REQ-007 in_prod  input  32  signed Q31 product from the upstream Q15xQ15 multiplier stage.
REQ-008 in_ready  output  1  block accepts a term this cycle.
REQ-009 out_valid  output  1  result registers hold a completed accumulation.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_acc  output  32  signed Q31 saturated accumulation result.
REQ-012 out_q15  output  16  signed Q15 rounded, saturated high half of out_acc.
REQ-013 sat_flag  output  1  sticky; set if any saturation occurred during this accumulation, including the rounding step.

Function
REQ-014 States SHALL be IDLE, ACCUM and DONE; reset state IDLE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 with len!=0 -> acc=0, cnt=len, sat_flag=0, next ACCUM.
REQ-016 IDLE: start=1 with len==0 -> acc=0, out_acc=0, out_q15=0, sat_flag=0, next DONE.
REQ-017 ACCUM: in_ready=1; a beat transfers only when in_valid&&in_ready; cycles without in_valid leave all state unchanged.
REQ-018 On each transfer: acc = sat_add(acc, in_prod); cnt = cnt-1; if cnt was 1, next state DONE.
REQ-019 sat_add SHALL form the 33-bit signed sum; >0x7FFFFFFF -> 0x7FFFFFFF, <-0x80000000 -> 0x80000000, and either clamp sets sat_flag.
REQ-020 On entry to DONE, out_acc SHALL be the final acc, and out_q15 SHALL be bits[31:16] of sat_add(final acc, 0x00008000); a rounding clamp sets sat_flag.
REQ-021 Latency: the last term accepted at edge k SHALL give out_valid=1 after edge k, with no extra cycle.
REQ-022 DONE: out_valid=1, in_ready=0; out_acc, out_q15 and sat_flag SHALL stay constant until out_valid&&out_ready, then next IDLE.
REQ-023 start SHALL be ignored in ACCUM and DONE, and in IDLE in the same cycle as the DONE->IDLE handshake (start is seen only from the following cycle).
REQ-024 in_ready SHALL be registered, a pure function of state; no combinational path from out_ready to in_ready.
REQ-025 The block SHALL complete a new start in IDLE the cycle after a DONE handshake, giving back-to-back throughput of len+2 cycles per result.

Reset
REQ-026 While rst_n=0, all of the following SHALL be forced immediately, regardless of clk: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_acc=0, out_q15=0, sat_flag=0.
REQ-027 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial/pending result; after release, the block SHALL wait for a fresh start.

Verification
REQ-028 len=2, in_prod 0x20000000, 0x10000000 -> out_acc=0x30000000, out_q15=0x3000, sat_flag=0, out_valid one cycle after the 2nd beat.
REQ-029 len=2, 0x7FFFFFFF then 0x00000001 -> out_acc=0x7FFFFFFF, out_q15=0x7FFF, sat_flag=1; len=2, 0x80000000 then 0xFFFFFFFF -> out_acc=0x80000000, out_q15=0x8000, sat_flag=1.
REQ-030 Rounding, len=1: 0x00018000 -> out_q15=0x0002; 0xFFFF7FFF -> out_q15=0xFFFF; 0x00007FFF -> out_q15=0x0000; all with sat_flag=0.
REQ-031 len=3, in_valid gapped (1,0,0,1,0,1), out_ready low 3 cycles then high, start pulsed in DONE -> result is the sum of the 3 terms, outputs held stable while out_ready is low, stray start ignored, IDLE after handshake.
REQ-032 len=0 start -> DONE next cycle with out_acc=0, out_q15=0; rst_n pulsed low mid-ACCUM after 1 of 4 beats -> all outputs 0 at once, IDLE, next start accumulates from 0.
